// File: rtl/dca_lsu_pkg.sv
// dca_lsu_pkg: shared types and constants for the DCA matrix LSU request/response path.
// Rev 1.0
`default_nettype none

package dca_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  localparam int DCA_BURDEN_LAST_BIT = 0;

  // Data beat width that base address and stride must be aligned to when the check is built in.
  localparam int DCA_BW_DATA = 128;

  function automatic int dca_cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dca_lsu_outstanding_cnt.sv
// dca_lsu_outstanding_cnt: saturating up/down counter with full/empty flags.
// Rev 1.0
`default_nettype none

module dca_lsu_outstanding_cnt #(
  parameter int MAX_VAL = 4,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             dec_eff;

  // A decrement at zero has nothing to retire, so it is dropped before netting against inc.
  always_comb begin
    dec_eff = dec_i && (count_q != '0);
    count_d = count_q;
    if (inc_i && !dec_eff && (count_q != CNT_W'(MAX_VAL))) begin
      count_d = count_q + CNT_W'(1);
    end else if (!inc_i && dec_eff) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q == CNT_W'(MAX_VAL));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/dca_matrix_lsu_req_gen.sv
// dca_matrix_lsu_req_gen: issues one LPIXM read per tile row with an outstanding-request cap.
// Rev 1.0; optional DCA_LSU_REQ_ALIGN_CHECK_EN enables the base/stride alignment check.
`default_nettype none

module dca_matrix_lsu_req_gen
  import dca_lsu_pkg::*;
#(
  parameter int BW_ADDR          = 32,
  parameter int MATRIX_SIZE_PARA = 4,
  parameter int BW_LPI_BURDEN    = 1,
  parameter int BW_STRIDE        = 16,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  start,
  input  logic [BW_ADDR-1:0]                    base_addr,
  input  logic [BW_STRIDE-1:0]                  stride,
  input  logic [$clog2(MATRIX_SIZE_PARA+1)-1:0] num_row,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic                                  req_valid,
  input  logic                                  req_ready,
  output logic [BW_ADDR-1:0]                    req_addr,
  output logic [BW_LPI_BURDEN-1:0]              req_burden,
  input  logic                                  rsp_row_done
);

  localparam int BW_ROW = $clog2(MATRIX_SIZE_PARA + 1);
  localparam int CNT_W  = dca_cnt_width(MAX_OUTSTANDING);

  lsu_state_e           state_q;
  logic [BW_ADDR-1:0]   row_addr_q;
  logic [BW_STRIDE-1:0] stride_q;
  logic [BW_ROW-1:0]    row_left_q;
  logic                 error_q;
  logic                 cnt_full;
  logic                 cnt_empty;
  logic                 req_hs;
  logic                 align_err;

`ifdef DCA_LSU_REQ_ALIGN_CHECK_EN
  assign align_err = ((base_addr & BW_ADDR'(DCA_BW_DATA / 8 - 1)) != '0) ||
                     ((stride & BW_STRIDE'(DCA_BW_DATA / 8 - 1)) != '0);
`else
  assign align_err = 1'b0;
`endif

  dca_lsu_outstanding_cnt #(
    .MAX_VAL (MAX_OUTSTANDING),
    .CNT_W   (CNT_W)
  ) u_outstanding_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .inc_i   (req_hs),
    .dec_i   (rsp_row_done),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  // Valid only ever falls through row_left (handshake) or the cap (which only grows on handshake).
  assign req_valid = (state_q == ST_ISSUE) && (row_left_q != '0) && !cnt_full;
  assign req_hs    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= ST_IDLE;
      row_addr_q <= '0;
      stride_q   <= '0;
      row_left_q <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            row_addr_q <= base_addr;
            stride_q   <= stride;
            row_left_q <= num_row;
            error_q    <= 1'b0;
            if (align_err) begin
              error_q    <= 1'b1;
              row_left_q <= '0;
              state_q    <= ST_DONE;
            end else if (num_row == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (req_hs) begin
            row_addr_q <= row_addr_q + BW_ADDR'(stride_q);
            row_left_q <= row_left_q - BW_ROW'(1);
            if (row_left_q == BW_ROW'(1)) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_empty && !rsp_row_done) begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    req_burden = '0;
    req_burden[DCA_BURDEN_LAST_BIT] = (row_left_q == BW_ROW'(1));
  end

  assign req_addr = row_addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign error    = error_q;

endmodule

`default_nettype wire

// File: tb/tb_dca_matrix_lsu_req_gen.sv
// tb_dca_matrix_lsu_req_gen: directed table, hand sequences and random tiles against a row/credit model.
// Rev 1.0
`default_nettype none

module tb_dca_matrix_lsu_req_gen;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] stride;
  logic [2:0]  num_row;
  logic        busy;
  logic        done;
  logic        error;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [0:0]  req_burden;
  logic        rsp_row_done;

  int checks = 0;
  int errors = 0;

  dca_matrix_lsu_req_gen dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .start        (start),
    .base_addr    (base_addr),
    .stride       (stride),
    .num_row      (num_row),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_burden   (req_burden),
    .rsp_row_done (rsp_row_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n;
    logic [31:0] base;
    logic [15:0] strd;
    int          rdy_pct;
    int          rsp_pct;
    int          exp_hs;
    logic [31:0] exp_last;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: rows issued so far and credits in flight; address of row i is base + i*stride.
  task automatic run_tile(input int n, input logic [31:0] b, input logic [15:0] s,
                          input int rdy_pct, input int rsp_pct,
                          output int hs, output logic [31:0] last_a);
    int          outs;
    int          issued;
    int          cyc;
    bit          done_exp;
    bit          done_next;
    bit          done_seen;
    bit          ev;
    bit          rdy_now;
    bit          rsp_now;
    logic [31:0] ea;
    start = 1'b1; base_addr = b; stride = s; num_row = 3'(n);
    req_ready = 1'b0; rsp_row_done = 1'b0;
    tick();
    start = 1'b0;
    outs = 0; issued = 0; hs = 0; cyc = 0; last_a = '0;
    done_exp = (n == 0); done_seen = 1'b0;
    while (!done_seen && cyc < 300) begin
      rdy_now = ($urandom_range(99) < rdy_pct);
      rsp_now = (outs > 0) && ($urandom_range(99) < rsp_pct);
      req_ready = rdy_now;
      rsp_row_done = rsp_now;
      ev = (issued < n) && (outs < MAX_OUT);
      ea = b + 32'(issued) * {16'h0, s};
      chk("tile_valid", req_valid, ev);
      if (ev) begin
        chk("tile_addr", req_addr, ea);
        chk("tile_burden", req_burden, (issued == n - 1));
      end
      chk("tile_done", done, done_exp);
      chk("tile_busy", busy, 1'b1);
      chk("tile_error", error, 1'b0);
      if (done) done_seen = 1'b1;
      done_next = !done_exp && (n > 0) && (issued == n) && (outs == 0) && !rsp_now;
      if (ev && rdy_now) begin
        hs++;
        last_a = ea;
        issued++;
        if (!rsp_now) outs++;
      end else if (rsp_now) begin
        outs--;
      end
      done_exp = done_next;
      tick();
      cyc++;
    end
    req_ready = 1'b0;
    rsp_row_done = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL tile_timeout: done not seen, got 0 expected 1");
    end
    chk("post_busy", busy, 1'b0);
    chk("post_done", done, 1'b0);
  endtask

  // Keeps ready high and pulses responses every other cycle until done; counts handshakes seen.
  task automatic drain_until_done(output int hs);
    bit seen;
    seen = 1'b0;
    hs = 0;
    for (int c = 0; c < 80 && !seen; c++) begin
      req_ready = 1'b1;
      rsp_row_done = c[0];
      if (done) seen = 1'b1;
      else if (req_valid) hs++;
      tick();
    end
    req_ready = 1'b0;
    rsp_row_done = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: done not seen, got 0 expected 1");
    end
  endtask

  initial begin
    int          hs;
    int          n;
    logic [31:0] la;
    logic [31:0] b;
    logic [15:0] s;

    tbl[0] = '{3, 32'h0000_1000, 16'h0040, 100, 100, 3, 32'h0000_1080};
    tbl[1] = '{1, 32'h0000_2000, 16'h0010, 100, 100, 1, 32'h0000_2000};
    tbl[2] = '{7, 32'h0000_0000, 16'h0100,  60,  40, 7, 32'h0000_0600};
    tbl[3] = '{4, 32'hFFFF_FF00, 16'h0080, 100,  30, 4, 32'h0000_0080};
    tbl[4] = '{0, 32'h0000_3000, 16'h0040, 100, 100, 0, 32'h0000_0000};
    tbl[5] = '{5, 32'h0000_0010, 16'hFFF0,  50,  50, 5, 32'h0003_FFD0};
    tbl[6] = '{2, 32'hFFFF_FFC0, 16'h0040, 100, 100, 2, 32'h0000_0000};

    rst = 1'b1; clear = 1'b0; start = 1'b0; base_addr = '0; stride = '0; num_row = '0;
    req_ready = 1'b0; rsp_row_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_valid", req_valid, 1'b0);
    chk("rst_addr", req_addr, 32'h0);
    chk("rst_burden", req_burden, 1'b0);

    for (int i = 0; i < 7; i++) begin
      run_tile(tbl[i].n, tbl[i].base, tbl[i].strd, tbl[i].rdy_pct, tbl[i].rsp_pct, hs, la);
      chk($sformatf("tbl%0d_hs", i), hs, tbl[i].exp_hs);
      chk($sformatf("tbl%0d_last", i), la, tbl[i].exp_last);
    end

    // Cap: six rows, no responses -> four handshakes then stall; one response frees the fifth.
    start = 1'b1; base_addr = 32'h4000; stride = 16'h20; num_row = 3'd6; req_ready = 1'b1;
    tick();
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      if (req_valid) hs++;
      tick();
    end
    chk("cap_hs", hs, 4);
    chk("cap_valid_low", req_valid, 1'b0);
    rsp_row_done = 1'b1;
    tick();
    rsp_row_done = 1'b0;
    chk("cap_reenable", req_valid, 1'b1);
    chk("cap_addr5", req_addr, 32'h4080);
    chk("cap_burden5", req_burden, 1'b0);
    drain_until_done(hs);
    chk("cap_rest_hs", hs, 2);
    tick();
    chk("cap_idle", busy, 1'b0);

    // Backpressure: addr/burden/valid hold while ready is low.
    start = 1'b1; base_addr = 32'h5000; stride = 16'h10; num_row = 3'd4; req_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_first_addr", req_addr, 32'h5000);
    tick();
    req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_valid_hold", req_valid, 1'b1);
      chk("bp_addr_hold", req_addr, 32'h5010);
      chk("bp_burden_hold", req_burden, 1'b0);
      tick();
    end
    drain_until_done(hs);
    chk("bp_rest_hs", hs, 3);
    tick();

    // Clear after two of four requests, then late responses must not leave credits behind.
    start = 1'b1; base_addr = 32'h6000; stride = 16'h40; num_row = 3'd4; req_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    clear = 1'b1; req_ready = 1'b0;
    tick();
    clear = 1'b0;
    chk("clr_busy", busy, 1'b0);
    chk("clr_valid", req_valid, 1'b0);
    chk("clr_addr", req_addr, 32'h0);
    chk("clr_done", done, 1'b0);
    rsp_row_done = 1'b1;
    tick(); tick(); tick();
    rsp_row_done = 1'b0;
    chk("clr_late_idle", busy, 1'b0);
    run_tile(2, 32'h7000, 16'h30, 100, 50, hs, la);
    chk("clr_restart_hs", hs, 2);
    chk("clr_restart_last", la, 32'h7030);

`ifdef DCA_LSU_REQ_ALIGN_CHECK_EN
    start = 1'b1; base_addr = 32'h1002; stride = 16'h40; num_row = 3'd3; req_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("align_error", error, 1'b1);
    chk("align_done", done, 1'b1);
    chk("align_valid", req_valid, 1'b0);
    tick();
    chk("align_sticky", error, 1'b1);
    chk("align_idle", busy, 1'b0);
    chk("align_no_req", req_valid, 1'b0);
    req_ready = 1'b0;
    run_tile(1, 32'h1000, 16'h40, 100, 100, hs, la);
    chk("align_recover_hs", hs, 1);
`endif

    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(7);
      b = $urandom & 32'hFFFF_FFF0;
      s = 16'($urandom) & 16'hFFF0;
      run_tile(n, b, s, $urandom_range(100, 20), $urandom_range(100, 10), hs, la);
      chk("rnd_hs", hs, n);
      if (n > 0) chk("rnd_last", la, b + 32'(n - 1) * {16'h0, s});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
